// File: rtl/nes_pad_poller.sv
// nes_pad_poller
// Sequences the NES controller shift-register read once per poll and
// publishes a coherent 8-bit button snapshot.
//
// Ports:
//   clock_50mhz  system clock
//   reset        synchronous, active-high reset
//   nes_data     serial pad data, asynchronous, active-low (0 = pressed)
//   poll_trig    external poll request (rising edge used when USE_EXT_TRIG=1)
//   clklatch     pad latch pulse
//   clkout       pad shift clock
//   buttons      active-high state: 0 A, 1 B, 2 Select, 3 Start,
//                4 Up, 5 Down, 6 Left, 7 Right
//   pressed      one-cycle pulse of bits newly pressed this poll
//   valid        one-cycle pulse when buttons/pressed update
//   busy         high from trigger acceptance through DONE
//   overrun      sticky; a trigger arrived while busy
module nes_pad_poller #(
  parameter int unsigned LATCH_CYCLES = 600,
  parameter int unsigned HALF_CYCLES  = 300,
  parameter int unsigned POLL_PERIOD  = 833333,
  parameter bit          USE_EXT_TRIG = 1'b0
) (
  input  logic       clock_50mhz,
  input  logic       reset,
  input  logic       nes_data,
  input  logic       poll_trig,
  output logic       clklatch,
  output logic       clkout,
  output logic [7:0] buttons,
  output logic [7:0] pressed,
  output logic       valid,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int unsigned PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int unsigned TW     = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  localparam logic [PW-1:0] LATCH_LAST = PW'(LATCH_CYCLES - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_CYCLES - 1);
  localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] phase;
  logic [PW-1:0] phase_next;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_next;
  logic [TW-1:0] timer;
  logic [7:0]    shift_reg;
  logic          data_ff1;
  logic          data_s;
  logic          poll_trig_q;
  logic          tick;
  logic          sample_en;
  logic          publish;

  // Trigger source selection
  always_comb begin
    if (USE_EXT_TRIG) begin
      tick = poll_trig & ~poll_trig_q;
    end else begin
      tick = (timer == POLL_LAST);
    end
  end

  // Free-running poll timer and input synchronizers
  always_ff @(posedge clock_50mhz) begin
    if (reset) begin
      timer       <= '0;
      data_ff1    <= 1'b0;
      data_s      <= 1'b0;
      poll_trig_q <= 1'b0;
    end else begin
      if (timer == POLL_LAST) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
      data_ff1    <= nes_data;
      data_s      <= data_ff1;
      poll_trig_q <= poll_trig;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    phase_next = phase;
    bit_next   = bit_idx;
    sample_en  = 1'b0;
    publish    = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          state_next = LATCH;
          phase_next = '0;
          bit_next   = '0;
        end
      end
      LATCH: begin
        if (phase == LATCH_LAST) begin
          state_next = LOW;
          phase_next = '0;
          bit_next   = '0;
        end else begin
          phase_next = phase + 1'b1;
        end
      end
      LOW: begin
        if (phase == HALF_LAST) begin
          sample_en  = 1'b1;
          state_next = HIGH;
          phase_next = '0;
        end else begin
          phase_next = phase + 1'b1;
        end
      end
      HIGH: begin
        if (phase == HALF_LAST) begin
          phase_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = DONE;
            publish    = 1'b1;
          end else begin
            bit_next   = bit_idx + 1'b1;
            state_next = LOW;
          end
        end else begin
          phase_next = phase + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs. Outputs are loaded from the
  // next state so they are valid during the state they describe; the
  // snapshot is published on entry to DONE so valid/buttons/pressed are
  // visible in the DONE cycle itself.
  always_ff @(posedge clock_50mhz) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      clklatch  <= 1'b0;
      clkout    <= 1'b0;
      buttons   <= '0;
      pressed   <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state    <= state_next;
      phase    <= phase_next;
      bit_idx  <= bit_next;
      clklatch <= (state_next == LATCH);
      clkout   <= (state_next == HIGH);
      busy     <= (state_next != IDLE);
      valid    <= publish;
      if (sample_en) begin
        shift_reg[bit_idx] <= ~data_s;
      end
      if (publish) begin
        buttons <= shift_reg;
        pressed <= shift_reg & ~buttons;
      end else begin
        pressed <= '0;
      end
      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nes_pad_poller.sv
// Testbench for nes_pad_poller: one instance on the internal timer, one on
// the external trigger, each with a shift-register pad model, compared
// every cycle against a timing/snapshot reference model.
module tb_nes_pad_poller;

  localparam int L = 4;
  localparam int H = 2;
  localparam int P = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic       trig_a = 1'b0;
  logic       trig_b = 1'b0;
  logic       nes_a;
  logic       nes_b;
  logic       clklatch_a, clkout_a, valid_a, busy_a, overrun_a;
  logic       clklatch_b, clkout_b, valid_b, busy_b, overrun_b;
  logic [7:0] buttons_a, pressed_a, buttons_b, pressed_b;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state, index 0 = internal timer, 1 = external trigger
  int         m_c[2];
  int         m_t[2];
  int         m_polls[2];
  logic [7:0] m_btn[2];
  logic [7:0] m_pad[2];
  logic       m_ovr[2];
  logic       m_ptrig[2];

  // Pad models: latch loads bit 0 onto the line, each clkout rise shifts on
  int idx_a = 8;
  int idx_b = 8;
  always @(posedge clklatch_a) idx_a = 0;
  always @(posedge clkout_a) if (idx_a < 8) idx_a = idx_a + 1;
  always @(posedge clklatch_b) idx_b = 0;
  always @(posedge clkout_b) if (idx_b < 8) idx_b = idx_b + 1;
  assign nes_a = (idx_a < 8) ? ~m_pad[0][idx_a[2:0]] : 1'b0;
  assign nes_b = (idx_b < 8) ? ~m_pad[1][idx_b[2:0]] : 1'b0;

  nes_pad_poller #(
    .LATCH_CYCLES(L),
    .HALF_CYCLES (H),
    .POLL_PERIOD (P),
    .USE_EXT_TRIG(1'b0)
  ) u_dut_a (
    .clock_50mhz(clk),
    .reset      (rst_a),
    .nes_data   (nes_a),
    .poll_trig  (trig_a),
    .clklatch   (clklatch_a),
    .clkout     (clkout_a),
    .buttons    (buttons_a),
    .pressed    (pressed_a),
    .valid      (valid_a),
    .busy       (busy_a),
    .overrun    (overrun_a)
  );

  nes_pad_poller #(
    .LATCH_CYCLES(L),
    .HALF_CYCLES (H),
    .POLL_PERIOD (P),
    .USE_EXT_TRIG(1'b1)
  ) u_dut_b (
    .clock_50mhz(clk),
    .reset      (rst_b),
    .nes_data   (nes_b),
    .poll_trig  (trig_b),
    .clklatch   (clklatch_b),
    .clkout     (clkout_b),
    .buttons    (buttons_b),
    .pressed    (pressed_b),
    .valid      (valid_b),
    .busy       (busy_b),
    .overrun    (overrun_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle of the reference model: compare the observed output vector
  // for the current cycle, then apply this cycle's reset/trigger.
  task automatic step(input int i, input logic [20:0] obs, input logic rst_now, input logic trig_now);
    int         c;
    int         t;
    int         done_c;
    int         o;
    logic       lat, clk_o, bsy, vld, tick;
    logic [7:0] prs;
    logic [20:0] exp;
    c      = m_c[i];
    t      = m_t[i];
    done_c = t + 1 + L + 16 * H;
    lat    = 1'b0;
    clk_o  = 1'b0;
    bsy    = 1'b0;
    vld    = 1'b0;
    prs    = 8'h00;
    if (t >= 0) begin
      lat = (c >= t + 1) && (c <= t + L);
      if (c >= t + L + 1 && c < done_c) begin
        o     = c - (t + L + 1);
        clk_o = ((o / H) % 2) == 1;
      end
      bsy = (c >= t + 1) && (c <= done_c);
      vld = (c == done_c);
    end
    if (vld) begin
      prs      = m_pad[i] & ~m_btn[i];
      m_btn[i] = m_pad[i];
      m_polls[i]++;
    end
    exp = {lat, clk_o, bsy, vld, m_ovr[i], m_btn[i], prs};
    check_val($sformatf("%s c%0d", (i == 0) ? "int" : "ext", c), 32'(obs), 32'(exp));
    if (vld) begin
      if (i == 0 && m_polls[i] == 1)      m_pad[i] = 8'h89;
      else if (i == 0 && m_polls[i] == 2) m_pad[i] = 8'h8A;
      else                                m_pad[i] = 8'($urandom);
    end
    if (rst_now) begin
      m_c[i]     = 0;
      m_t[i]     = -1;
      m_btn[i]   = 8'h00;
      m_ovr[i]   = 1'b0;
      m_ptrig[i] = 1'b0;
    end else begin
      if (i == 0) tick = ((c % P) == P - 1);
      else        tick = trig_now & ~m_ptrig[i];
      m_ptrig[i] = trig_now;
      if (tick) begin
        if (t < 0 || c > done_c) m_t[i] = c;
        else                     m_ovr[i] = 1'b1;
      end
      m_c[i] = c + 1;
    end
  endtask

  initial begin
    logic [20:0] obs_a;
    logic [20:0] obs_b;
    int          rst_hold;
    bit          mid_done;
    int          cb;
    rst_hold = 0;
    mid_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_c[i]     = 0;
      m_t[i]     = -1;
      m_polls[i] = 0;
      m_btn[i]   = 8'h00;
      m_ovr[i]   = 1'b0;
      m_ptrig[i] = 1'b0;
    end
    m_pad[0] = 8'h89;
    m_pad[1] = 8'($urandom);

    for (int g = 0; g < 1700; g++) begin
      @(negedge clk);
      obs_a = {clklatch_a, clkout_a, busy_a, valid_a, overrun_a, buttons_a, pressed_a};
      obs_b = {clklatch_b, clkout_b, busy_b, valid_b, overrun_b, buttons_b, pressed_b};

      // Internal-timer instance: power-on reset, then a reset landing in
      // the HIGH phase of bit 4 during the eleventh poll.
      if (g < 4) begin
        rst_a = 1'b1;
      end else if (rst_hold > 0) begin
        rst_a = 1'b1;
        rst_hold--;
      end else begin
        rst_a = 1'b0;
      end
      if (!mid_done && m_polls[0] == 10 && m_t[0] >= 0 &&
          m_c[0] == m_t[0] + 1 + L + 9 * H) begin
        mid_done = 1'b1;
        rst_a    = 1'b1;
        rst_hold = 2;
      end

      // External-trigger instance: edge at 10, edge while busy at 20,
      // a 50-cycle hold, then random pulses.
      rst_b = (g < 4);
      cb    = m_c[1];
      trig_b = (cb == 10) || (cb == 20) || (cb >= 100 && cb < 150) ||
               (cb >= 200 && $urandom_range(0, 24) == 0);

      check_val($sformatf("excl_a c%0d", m_c[0]), 32'(clklatch_a & clkout_a), 32'd0);
      check_val($sformatf("excl_b c%0d", m_c[1]), 32'(clklatch_b & clkout_b), 32'd0);

      step(0, obs_a, rst_a, trig_a);
      step(1, obs_b, rst_b, trig_b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/nes_pad_poller.md
Name: nes_pad_poller

Overview:
- Scheduler that sequences the NES controller shift-register read for the video path.
- Generates `clklatch`/`clkout` timing, samples `nes_data` serially and publishes an 8-bit button vector with a one-cycle valid strobe.
- Polls on an internal ~60 Hz timer or on an external frame trigger (e.g. `vsync` start), so the game/VGA logic sees one coherent pad snapshot per frame.

Parameters:
- LATCH_CYCLES, 600, `clklatch` high time in clocks (12 us at 50 MHz).
- HALF_CYCLES, 300, duration of each `clkout` low or high phase (6 us).
- POLL_PERIOD, 833333, internal trigger period in clocks (60 Hz); must be greater than LATCH_CYCLES+16*HALF_CYCLES+2.
- USE_EXT_TRIG, 0, 1 selects `poll_trig` rising edge as the trigger; 0 selects the internal timer.

Ports:
- clock_50mhz  input  1  system clock
- reset  input  1  synchronous, active-high reset
- nes_data  input  1  serial pad data, asynchronous, active-low (0 = pressed)
- poll_trig  input  1  external poll request; rising edge used when USE_EXT_TRIG=1
- clklatch  output  1  pad latch pulse
- clkout  output  1  pad shift clock
- buttons  output  8  active-high state; bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right
- pressed  output  8  one-cycle pulse, bits newly pressed this poll
- valid  output  1  one-cycle pulse when `buttons`/`pressed` update
- busy  output  1  high from trigger acceptance through DONE
- overrun  output  1  sticky; set when a trigger arrives while busy

Behaviour:
- Reset (sampled on `clock_50mhz` edge) is synchronous and active-high.
  - All outputs go to 0; state goes to IDLE.
  - Poll timer, bit counter, phase counter and sync/edge flops clear.
- Reset mid-sequence aborts immediately; no partial `buttons` update.
- `nes_data` passes through a 2-flop synchronizer. "data_s" is the second flop. Sampled value is ~data_s.
- Trigger sources:
  - Internal: counter 0..POLL_PERIOD-1; tick on the cycle it equals POLL_PERIOD-1, then wraps to 0. The first tick after reset is at cycle POLL_PERIOD-1.
  - External: tick = `poll_trig` & ~poll_trig_q. `poll_trig` is registered once; no further sync is required, since it comes from the same clock domain.
- A tick in IDLE is accepted. A tick in any other state is dropped and sets `overrun`.
- FSM:
  - IDLE: `busy`=0, `clklatch`=0, `clkout`=0. On accepted tick go to LATCH with counters cleared.
  - LATCH: `clklatch`=1 for exactly LATCH_CYCLES cycles, then go to LOW with bit index k=0.
  - LOW: `clkout`=0 for HALF_CYCLES cycles. On the last cycle, shift register bit k <= ~data_s. Then go to HIGH.
  - HIGH: `clkout`=1 for HALF_CYCLES cycles. Then if k==7 go to DONE; else k<=k+1 and go to LOW. This gives 8 clkout pulses and 8 samples.
  - DONE: one cycle.
    - `buttons` <= shift register.
    - `pressed` <= shift register & ~old buttons.
    - `valid`=1.
    - Next state is IDLE.
- `valid` and `pressed` are registered and nonzero only in the DONE cycle; otherwise `pressed`=0.
- `busy`=1 in LATCH, LOW, HIGH and DONE.
- Latency:
  - Tick accepted on cycle t; `clklatch` is high on cycles t+1..t+LATCH_CYCLES.
  - `valid` asserts on cycle t+1+LATCH_CYCLES+16*HALF_CYCLES (t+5401 at defaults).
- A tick coinciding with the DONE cycle counts as arriving while busy: it is dropped and sets `overrun`.
- `clklatch` and `clkout` are never high simultaneously. Both are driven directly from registers (glitch-free).
- Counter widths are sized via $clog2 of the respective parameter.

Test Plan:
Sim parameters: LATCH_CYCLES=4, HALF_CYCLES=2, POLL_PERIOD=100, USE_EXT_TRIG=0.
- Reset then idle:
  - Required: all outputs 0 through cycle 98.
  - Required: `clklatch` rises on cycle 100, high for exactly 4 cycles.
  - Required: 8 `clkout` pulses, each 2 high / 2 low.
  - Required: `valid` pulses once at tick+37.
- Pad model drives A, Start, Right pressed (`nes_data` low at bits 0, 3, 7) -> `buttons`=8'h89 and `pressed`=8'h89 on first `valid`.
- Same pad state on next poll -> `buttons`=8'h89, `pressed`=8'h00.
- Then release A, press B -> `pressed`=8'h02, `buttons`=8'h8A.
- USE_EXT_TRIG=1 (POLL_PERIOD=100):
  - `poll_trig` pulses at cycle 10 -> sequence starts next cycle and `valid` is at 10+37.
  - A second `poll_trig` edge at cycle 20 -> dropped, `overrun`=1 and remains 1.
  - Holding `poll_trig` high for 50 cycles -> only one poll.
- Assert `reset` during the HIGH phase of bit 4 -> next cycle all outputs 0 and previous `buttons` cleared; next `valid` only after a fresh trigger.
- Assertion bench over 10 polls:
  - `clklatch` & `clkout` is never 1.
  - `valid` is exactly 1 cycle wide.
  - `busy` is 0 in every cycle between DONE and the next accepted tick.
